// File: rtl/cvp14_mem_ctrl.sv
// cvp14_mem_ctrl: core-side memory controller with a posted write buffer.
// Reads return on the following cycle; writes queue and drain to a
// single-port synchronous SRAM whenever RD is low.
module cvp14_mem_ctrl #(
    parameter int AW    = 16,
    parameter int DEPTH = 4,
    parameter int PW    = 2
) (
    input  logic          Clk1,
    input  logic          Reset,
    input  logic [15:0]   Addr,
    input  logic          RD,
    input  logic          WR,
    input  logic          V,
    input  logic [15:0]   WrData,
    output logic [15:0]   DataIn,
    output logic [AW-1:0] sram_addr,
    output logic          sram_re,
    output logic          sram_we,
    output logic [15:0]   sram_wdata,
    input  logic [15:0]   sram_rdata,
    output logic [PW:0]   wb_count,
    output logic          idle,
    output logic          err_ovf,
    output logic          err_rdwr,
    output logic [15:0]   vec_beats
);

    logic [AW-1:0] buf_addr [DEPTH];
    logic [15:0]   buf_data [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [PW:0]   count_q;
    logic          rd_pend_q;
    logic          fwd_hit_q;
    logic [15:0]   fwd_data_q;
    logic [15:0]   hold_q;

    logic          rd_acc;
    logic          full;
    logic          drain;
    logic          push;
    logic          fwd_hit;
    logic [15:0]   fwd_data;
    logic [15:0]   rd_data;

    // Request decode; RD owns the SRAM port even when it loses to WR,
    // so a conflicting RD+WR cycle never pops the buffer.
    always_comb begin
        rd_acc = RD & ~WR;
        full   = (count_q == (PW+1)'(DEPTH));
        drain  = ~RD & (count_q != '0);
        push   = WR & (~full | drain);
    end

    // Scan valid entries oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (((PW+1)'(i) < count_q) &&
                (buf_addr[head_q + PW'(i)] == Addr[AW-1:0])) begin
                fwd_hit  = 1'b1;
                fwd_data = buf_data[head_q + PW'(i)];
            end
        end
    end

    // Output muxing: read data is live in the cycle after a read, then held.
    always_comb begin
        rd_data    = fwd_hit_q ? fwd_data_q : sram_rdata;
        DataIn     = rd_pend_q ? rd_data : hold_q;
        sram_re    = rd_acc & ~Reset;
        sram_we    = drain & ~Reset;
        sram_addr  = rd_acc ? Addr[AW-1:0] : buf_addr[head_q];
        sram_wdata = buf_data[head_q];
        wb_count   = count_q;
        idle       = (count_q == '0) & ~rd_pend_q;
    end

    // Buffer storage; contents need no reset since the pointers define validity.
    always_ff @(posedge Clk1) begin
        if (push && !Reset) begin
            buf_addr[tail_q] <= Addr[AW-1:0];
            buf_data[tail_q] <= WrData;
        end
    end

    // Pointers, occupancy, read pipeline, sticky flags and beat counter.
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rd_pend_q  <= 1'b0;
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
            hold_q     <= '0;
            err_ovf    <= 1'b0;
            err_rdwr   <= 1'b0;
            vec_beats  <= '0;
        end else begin
            if (push) tail_q <= tail_q + PW'(1);
            if (drain) head_q <= head_q + PW'(1);
            case ({push, drain})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
            rd_pend_q <= rd_acc;
            if (rd_acc) begin
                fwd_hit_q  <= fwd_hit;
                fwd_data_q <= fwd_data;
            end
            if (rd_pend_q) hold_q <= rd_data;
            if (WR && !push) err_ovf <= 1'b1;
            if (RD && WR) err_rdwr <= 1'b1;
            if ((rd_acc || WR) && V) vec_beats <= vec_beats + 16'd1;
        end
    end

endmodule
